// File: rtl/color_video_out_pkg.sv
// Shared definitions for the colour video output path.
//   - Palette word field positions (IIII_RRRR_GGGG_BBBB).
//   - Output mode enum (live video or colour bars).
//   - Packed 8-bit RGB triple.
//   - Helper that builds the colour-bar palette word for a bar index.
package color_video_out_pkg;

    localparam int I_MSB = 15;
    localparam int R_MSB = 11;
    localparam int G_MSB = 7;
    localparam int B_MSB = 3;

    typedef enum logic {
        NORMAL = 1'b0,
        BARS   = 1'b1
    } mode_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    // Full intensity, with each colour nibble lit by one bit of the bar index:
    // bar 0 is black, bar 7 is white.
    function automatic logic [15:0] bar_word(input logic [2:0] bar);
        return {4'hF, {4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
    endfunction

endpackage

// File: rtl/color_video_out_if.sv
// Video bus between the colour-RAM side and the monitor side.
//   pix_en, color_in, blank_in, hsync_in, vsync_in, test_mode : towards the block
//   red, green, blue, hsync_out, vsync_out, de_out             : from the block
// master: the driver of the input stream (and reader of the outputs).
// slave : the colour video output block.
interface color_video_out_if;

    logic        pix_en;
    logic [15:0] color_in;
    logic        blank_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        test_mode;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hsync_out;
    logic        vsync_out;
    logic        de_out;

    modport master (
        output pix_en, color_in, blank_in, hsync_in, vsync_in, test_mode,
        input  red, green, blue, hsync_out, vsync_out, de_out
    );

    modport slave (
        input  pix_en, color_in, blank_in, hsync_in, vsync_in, test_mode,
        output red, green, blue, hsync_out, vsync_out, de_out
    );

endinterface

// File: rtl/intensity_scale.sv
// Combinational intensity scaling of one 4-bit colour channel.
//   c : 4-bit channel value
//   i : 4-bit intensity
//   y : 8-bit linear value c*(i+1); peaks at 15*16 = 240, so it never overflows.
module intensity_scale (
    input  logic [3:0] c,
    input  logic [3:0] i,
    output logic [7:0] y
);

    assign y = {4'd0, c} * ({4'd0, i} + 8'd1);

endmodule

// File: rtl/color_video_out.sv
// Colour video output stage.
// Decodes IIII_RRRR_GGGG_BBBB palette words into 8-bit linear RGB, forces
// black outside the active display and keeps sync/blank aligned with the data
// through a two-strobe pipeline. A colour-bar pattern can replace the live
// words; the request is only honoured at vsync edges so a frame never tears.
//   clk, rst : clock and synchronous active-high reset
//   vif      : video bus (slave side), see color_video_out_if
module color_video_out
    import color_video_out_pkg::*;
#(
    parameter int BAR_WIDTH = 42,
    parameter int LATENCY   = 2
) (
    input logic              clk,
    input logic              rst,
    color_video_out_if.slave vif
);

    generate
        if (LATENCY != 2) begin : g_latency_check
            $error("color_video_out: LATENCY is fixed at 2");
        end
    endgenerate

    localparam logic [8:0] BAR_W9 = 9'(BAR_WIDTH);

    mode_t       mode;
    mode_t       mode_next;
    logic        vsync_prev;
    logic        frame_edge;
    logic [8:0]  x_cnt;
    logic [8:0]  bar_q;
    logic [2:0]  bar;
    logic [15:0] sel_color;

    logic [15:0] color_p1;
    logic        de_p1;
    logic        hsync_p1;
    logic        vsync_p1;

    logic [7:0]  red_s;
    logic [7:0]  green_s;
    logic [7:0]  blue_s;
    rgb8_t       rgb_p2;
    logic        hsync_p2;
    logic        vsync_p2;
    logic        de_p2;

    // Either vsync edge marks a frame boundary.
    assign frame_edge = vif.pix_en && (vif.vsync_in != vsync_prev);

    always_comb begin
        mode_next = mode;
        if (frame_edge) begin
            mode_next = vif.test_mode ? BARS : NORMAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= NORMAL;
        end else begin
            mode <= mode_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev <= 1'b0;
            x_cnt      <= 9'd0;
        end else if (vif.pix_en) begin
            vsync_prev <= vif.vsync_in;
            if (vif.blank_in) begin
                x_cnt <= 9'd0;
            end else if (x_cnt != 9'h1FF) begin
                x_cnt <= x_cnt + 9'd1;
            end
        end
    end

    // Over-long lines stay on the last (white) bar.
    always_comb begin
        bar_q = x_cnt / BAR_W9;
        bar   = (bar_q > 9'd7) ? 3'd7 : bar_q[2:0];
    end

    // The registered mode is used, so the pixel on a frame edge is still
    // rendered with the previous mode.
    assign sel_color = (mode == BARS) ? bar_word(bar) : vif.color_in;

    // Stage 1: capture selected word and controls. de is stored rather than
    // blank so the cleared state reads as "not displayable".
    always_ff @(posedge clk) begin
        if (rst) begin
            color_p1 <= 16'd0;
            de_p1    <= 1'b0;
            hsync_p1 <= 1'b0;
            vsync_p1 <= 1'b0;
        end else if (vif.pix_en) begin
            color_p1 <= sel_color;
            de_p1    <= ~vif.blank_in;
            hsync_p1 <= vif.hsync_in;
            vsync_p1 <= vif.vsync_in;
        end
    end

    intensity_scale u_scale_r (
        .c (color_p1[R_MSB -: 4]),
        .i (color_p1[I_MSB -: 4]),
        .y (red_s)
    );

    intensity_scale u_scale_g (
        .c (color_p1[G_MSB -: 4]),
        .i (color_p1[I_MSB -: 4]),
        .y (green_s)
    );

    intensity_scale u_scale_b (
        .c (color_p1[B_MSB -: 4]),
        .i (color_p1[I_MSB -: 4]),
        .y (blue_s)
    );

    // Stage 2: scaled, blank-forced colour and aligned syncs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_p2   <= '0;
            hsync_p2 <= 1'b0;
            vsync_p2 <= 1'b0;
            de_p2    <= 1'b0;
        end else if (vif.pix_en) begin
            rgb_p2   <= de_p1 ? '{r: red_s, g: green_s, b: blue_s} : '0;
            hsync_p2 <= hsync_p1;
            vsync_p2 <= vsync_p1;
            de_p2    <= de_p1;
        end
    end

    assign vif.red       = rgb_p2.r;
    assign vif.green     = rgb_p2.g;
    assign vif.blue      = rgb_p2.b;
    assign vif.hsync_out = hsync_p2;
    assign vif.vsync_out = vsync_p2;
    assign vif.de_out    = de_p2;

endmodule

// File: tb/tb_color_video_out.sv
// Directed bench for color_video_out: table of pixel vectors with expected
// outputs, replayed with and without pix_en stalls, plus reset, colour-bar
// and deferred mode-switch sequences.
module tb_color_video_out;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    color_video_out_if vif ();

    color_video_out #(.BAR_WIDTH(42), .LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .vif (vif)
    );

    typedef struct {
        logic [15:0] color;
        logic        blank;
        logic        hs;
        logic        vs;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        ehs;
        logic        evs;
        logic        de;
    } vec_t;

    typedef struct {
        int         x;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } bar_chk_t;

    vec_t     tbl[9];
    bar_chk_t bars[10];

    task automatic check(input string name, input logic [7:0] r, g, b,
                         input logic hs, vs, de);
        n_vec++;
        if (vif.red !== r || vif.green !== g || vif.blue !== b ||
            vif.hsync_out !== hs || vif.vsync_out !== vs || vif.de_out !== de) begin
            n_err++;
            $display("FAIL %s: got r=%0d g=%0d b=%0d hs=%0b vs=%0b de=%0b, want r=%0d g=%0d b=%0d hs=%0b vs=%0b de=%0b",
                     name, vif.red, vif.green, vif.blue, vif.hsync_out, vif.vsync_out,
                     vif.de_out, r, g, b, hs, vs, de);
        end
    endtask

    // One pixel strobe, then `stall` idle clocks. Returns #1 after the last edge.
    task automatic strobe(input logic [15:0] c, input logic bl, hs, vs, tm,
                          input int stall);
        vif.color_in  = c;
        vif.blank_in  = bl;
        vif.hsync_in  = hs;
        vif.vsync_in  = vs;
        vif.test_mode = tm;
        vif.pix_en    = 1'b1;
        @(posedge clk);
        #1;
        vif.pix_en = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vif.pix_en = i[0];
            @(posedge clk);
            #1;
        end
        rst        = 1'b0;
        vif.pix_en = 1'b0;
    endtask

    task automatic run_table(input logic stalls);
        for (int k = 0; k < 9; k++) begin
            int st;
            st = stalls ? int'($urandom_range(1, 4)) : 0;
            strobe(tbl[k].color, tbl[k].blank, tbl[k].hs, tbl[k].vs, 1'b0, st);
            check($sformatf("%s_vec%0d", stalls ? "stall" : "plain", k),
                  tbl[k].r, tbl[k].g, tbl[k].b, tbl[k].ehs, tbl[k].evs, tbl[k].de);
        end
    endtask

    initial begin
        // Expected outputs after each strobe reflect the previous row.
        tbl[0] = '{16'hF8F0, 1'b0, 1'b0, 1'b0,   8'd0,   8'd0,  8'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'h0F00, 1'b0, 1'b0, 1'b0, 8'd128, 8'd240,  8'd0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{16'hFFFF, 1'b1, 1'b0, 1'b0,  8'd15,   8'd0,  8'd0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{16'h1234, 1'b0, 1'b1, 1'b0,   8'd0,   8'd0,  8'd0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{16'h3A5C, 1'b0, 1'b0, 1'b0,   8'd4,   8'd6,  8'd8, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{16'h0000, 1'b1, 1'b0, 1'b1,  8'd40,  8'd20, 8'd48, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{16'h7777, 1'b0, 1'b0, 1'b1,   8'd0,   8'd0,  8'd0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{16'h0000, 1'b0, 1'b0, 1'b1,  8'd56,  8'd56, 8'd56, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{16'h0000, 1'b0, 1'b0, 1'b1,   8'd0,   8'd0,  8'd0, 1'b0, 1'b1, 1'b1};

        bars[0] = '{0,     8'd0,   8'd0,   8'd0};
        bars[1] = '{41,    8'd0,   8'd0,   8'd0};
        bars[2] = '{42,    8'd0,   8'd0, 8'd240};
        bars[3] = '{84,    8'd0, 8'd240,   8'd0};
        bars[4] = '{126,   8'd0, 8'd240, 8'd240};
        bars[5] = '{168, 8'd240,   8'd0,   8'd0};
        bars[6] = '{293, 8'd240, 8'd240,   8'd0};
        bars[7] = '{294, 8'd240, 8'd240, 8'd240};
        bars[8] = '{335, 8'd240, 8'd240, 8'd240};
        bars[9] = '{500, 8'd240, 8'd240, 8'd240};

        vif.pix_en    = 1'b0;
        vif.color_in  = 16'hFFFF;
        vif.blank_in  = 1'b0;
        vif.hsync_in  = 1'b1;
        vif.vsync_in  = 1'b1;
        vif.test_mode = 1'b0;
        @(posedge clk);
        #1;

        do_reset();
        check("reset", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        run_table(1'b0);

        // Mid-frame reset: stale pipeline must not leak out.
        vif.color_in = 16'hFFFF;
        vif.blank_in = 1'b0;
        do_reset();
        check("midreset", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        strobe(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("midreset_1strobe", 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        strobe(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("midreset_2strobe", 8'd240, 8'd240, 8'd240, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("hold_no_strobe", 8'd240, 8'd240, 8'd240, 1'b0, 1'b0, 1'b1);

        // Same table with random stalls; the output sequence must not change.
        do_reset();
        run_table(1'b1);

        // Colour bars: enable at a vsync edge, then one long active line.
        do_reset();
        strobe(16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        strobe(16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        for (int x = 0; x <= 501; x++) begin
            strobe(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 0);
            for (int j = 0; j < 10; j++) begin
                if (x - 1 == bars[j].x) begin
                    check($sformatf("bars_x%0d", bars[j].x),
                          bars[j].r, bars[j].g, bars[j].b, 1'b0, 1'b1, 1'b1);
                end
            end
        end

        // Deferred switch: mid-frame request waits for the next vsync edge.
        do_reset();
        strobe(16'h0F00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        strobe(16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        strobe(16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        strobe(16'h0F00, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        strobe(16'h0F00, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("defer_midframe_a", 8'd15, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        strobe(16'h0F00, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        check("defer_midframe_b", 8'd15, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        strobe(16'h0F00, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        check("defer_edge_pixel_live", 8'd15, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
        strobe(16'h0F00, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        check("defer_next_pixel_bar", 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
